mux16_rr_arbiter: RTL
=====================

// Module: mux16_rr_arbiter
// PURPOSE
//  - Round-robin scheduler that shares one 16:1 single-bit mux datapath among 16 requesters.
//  - Issues a one-hot grant and drives the 4-bit select. Captures the selected data bit into a registered output with a valid flag.
//  - Sits between the requester bank and the mux; it owns the select lines exclusively.
// PARAMETERS
//  - N        16  number of requesters and mux inputs; fixed at 16 by the select width
//  - SEL_W    4   select width, equal to log2(N)
//  - MAX_HOLD 8   maximum BUSY cycles per grant; used only when MUXARB_TIMEOUT_EN is defined; range 1..255
// PORTS
//  - clk    in   1      single clock; all state updates on the rising edge
//  - rst_n  in   1      asynchronous, active-low reset
//  - req    in   16     request vector; req[i] is held high while requester i wants the mux
//  - done   in   1      the current owner releases the grant; sampled only in BUSY
//  - d      in   16     mux data inputs; d[i] belongs to requester i
//  - gnt    out  16     one-hot grant, registered; all-zero when nobody owns the mux
//  - sel    out  4      registered mux select; equals the index of the set gnt bit
//  - y      out  1      registered mux output, d[sel] from the previous cycle
//  - valid  out  1      y holds data from an active grant
// BEHAVIOUR
//  - Reset: asynchronous, takes effect immediately with no clock edge needed.
//    - state=IDLE, gnt=0, sel=0, y=0, valid=0, hold_cnt=0
//    - ptr=15, so the first search starts at requester 0
//  - States: IDLE -> BUSY -> RELEASE -> IDLE. No other transitions exist.
//  - IDLE:
//    - If req==0, stay in IDLE.
//    - Otherwise, search indices ptr+1, ptr+2, ... mod 16; the first i with req[i]=1 wins.
//    - Next edge: gnt=1<<i, sel=i, ptr=i, hold_cnt=0, state=BUSY.
//    - Latency from req rising to gnt is 1 cycle.
//  - BUSY:
//    - Each edge: y <= d[sel]; valid <= 1. valid first rises 1 cycle after gnt.
//    - Release if any of: done=1, req[sel]=0, or (timeout build) hold_cnt==MAX_HOLD-1.
//    - On release: next edge gnt=0, state=RELEASE; sel keeps its value.
//    - Otherwise hold_cnt increments, saturating at 255.
//  - RELEASE:
//    - Exactly one cycle. gnt=0, valid<=0, y holds its last value.
//    - Next state is IDLE. The minimum gap between two grants is therefore 2 cycles of gnt=0.
//  - Simultaneous events:
//    - Requests from other requesters during BUSY/RELEASE are not observed until IDLE.
//    - done together with req[sel] drop counts as a single release.
//    - done outside BUSY is ignored.
//  - Fairness: the winner becomes the lowest priority for the next search. With all 16 requesting, each gets a grant once per 16 grants.
//  - Invariants: gnt is zero or one-hot; gnt!=0 only in BUSY; when gnt!=0, sel==index(gnt).
// CONFIGURATION
//  - MUXARB_TIMEOUT_EN defined:
//    - hold_cnt is compared against MAX_HOLD.
//    - A grant is force-released after MAX_HOLD BUSY cycles even if done never arrives.
//  - MUXARB_TIMEOUT_EN undefined:
//    - No hold counter logic is built.
//    - A grant lasts until done=1 or req[sel]=0, with no upper bound.
//    - MAX_HOLD is ignored.
// STRUCTURE
//  - Package mux_arb_pkg holds:
//    - localparams N=16 and SEL_W=4
//    - typedef enum logic[1:0] arb_state_t {IDLE, BUSY, RELEASE}
//    - typedef logic[SEL_W-1:0] sel_t
//  - Sub-module rr_next_sel is purely combinational.
//    - Inputs: req[15:0], ptr[3:0]. Outputs: found, idx[3:0].
//    - It rotates req by ptr+1, priority-encodes the lowest set bit, then un-rotates the index.
//  - The top level holds the FSM, ptr, hold_cnt and the registered datapath (gnt/sel/y/valid).
// TESTING
//  - Reset:
//    - rst_n=0 while req=16'hFFFF: gnt=0, sel=0, y=0, valid=0 with no clock edge.
//    - Release reset: the first grant is gnt=16'h0001, sel=0.
//  - Round robin: req=16'h8101 held, done pulsed once per grant.
//    - Grant order is sel=0,8,15,0,8 with a 2-cycle gnt=0 gap between grants.
//  - Datapath: grant requester 5 with d=16'h0020.
//    - y=1 and valid=1 one cycle after gnt.
//    - Toggle d[5]: y follows with a 1-cycle lag.
//    - Toggle d[4]: y is unaffected.
//  - Release by drop: requester 3 in BUSY, req[3] falls.
//    - Next edge gnt=0 (RELEASE), then IDLE.
//    - The next grant goes to the lowest requesting index above 3.
//  - Timeout (MUXARB_TIMEOUT_EN, MAX_HOLD=8): req=16'h0003, done held at 0.
//    - Requester 0 owns the mux for 8 cycles, then requester 1.
//    - Without the macro, requester 0 owns it indefinitely.
//  - Reset mid-BUSY: assert rst_n=0 asynchronously.
//    - gnt, valid and y clear immediately; ptr=15.
//    - After reset, req=16'h0004 grants sel=2.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and sizes for the 16-requester round-robin mux arbiter.
// Combinational only: no latency and no backpressure apply.
package mux_arb_pkg;

    localparam int N     = 16;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } arb_state_t;

    typedef logic [SEL_W-1:0] sel_t;

endpackage

// File: rtl/rr_next_sel.sv
// Combinational round-robin search: the first set req bit strictly after ptr, wrapping modulo N.
// Latency 0 cycles. There is no backpressure: found is low when req is all zero.
module rr_next_sel
    import mux_arb_pkg::*;
(
    input  logic [N-1:0] req,
    input  sel_t         ptr,
    output logic         found,
    output sel_t         idx
);

    sel_t           w_start;
    logic [2*N-1:0] w_dbl;
    logic [N-1:0]   w_rot;
    sel_t           w_off;

    assign w_start = ptr + 1'b1;
    // Doubling the vector before the shift makes it a rotate, so bit 0 of w_rot is req[ptr+1].
    assign w_dbl   = {req, req} >> w_start;
    assign w_rot   = w_dbl[N-1:0];

    always_comb begin
        w_off = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_off = sel_t'(i);
            end
        end
    end

    assign found = |req;
    assign idx   = w_start + w_off;

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin owner of a 16:1 single-bit mux: registered one-hot grant, select, data and valid. Optional MUXARB_TIMEOUT_EN caps each grant at MAX_HOLD cycles.
// Latency: grant 1 cycle after req; y/valid 1 cycle after the grant; at least 2 idle cycles between grants.
// Backpressure: the owner holds the mux until done, until its req drops, or until the timeout (timeout build only).
module mux16_rr_arbiter
    import mux_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         done,
    input  logic [N-1:0] d,
    output logic [N-1:0] gnt,
    output sel_t         sel,
    output logic         y,
    output logic         valid
);

`ifdef MUXARB_TIMEOUT_EN
    parameter int MAX_HOLD = 8;
    logic [7:0] r_hold_cnt;
    logic [7:0] w_hold_nxt;
`endif

    arb_state_t   r_state, w_state_nxt;
    sel_t         r_ptr, w_ptr_nxt;
    logic [N-1:0] r_gnt, w_gnt_nxt;
    sel_t         r_sel, w_sel_nxt;
    logic         r_y, w_y_nxt;
    logic         r_valid, w_valid_nxt;
    logic         w_release;
    logic         w_found;
    sel_t         w_idx;

    rr_next_sel u_next (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= sel_t'(N - 1);
            r_gnt   <= '0;
            r_sel   <= '0;
            r_y     <= 1'b0;
            r_valid <= 1'b0;
`ifdef MUXARB_TIMEOUT_EN
            r_hold_cnt <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_y     <= w_y_nxt;
            r_valid <= w_valid_nxt;
`ifdef MUXARB_TIMEOUT_EN
            r_hold_cnt <= w_hold_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_y_nxt     = r_y;
        w_valid_nxt = r_valid;
        w_release   = done || !req[r_sel];
`ifdef MUXARB_TIMEOUT_EN
        w_hold_nxt  = r_hold_cnt;
        w_release   = w_release || (r_hold_cnt == 8'(MAX_HOLD - 1));
`endif
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_gnt_nxt        = '0;
                    w_gnt_nxt[w_idx] = 1'b1;
                    w_sel_nxt        = w_idx;
                    w_ptr_nxt        = w_idx;
                    w_state_nxt      = BUSY;
`ifdef MUXARB_TIMEOUT_EN
                    w_hold_nxt       = '0;
`endif
                end
            end
            BUSY: begin
                w_y_nxt     = d[r_sel];
                w_valid_nxt = 1'b1;
                if (w_release) begin
                    w_gnt_nxt   = '0;
                    w_state_nxt = RELEASE;
                end else begin
`ifdef MUXARB_TIMEOUT_EN
                    if (r_hold_cnt != 8'hFF) begin
                        w_hold_nxt = r_hold_cnt + 8'd1;
                    end
`endif
                end
            end
            RELEASE: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = IDLE;
            end
            default: begin
                w_gnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign y     = r_y;
    assign valid = r_valid;

endmodule
